// File: rtl/result_store_writer_pkg.sv
// Shared constants, state encoding and helpers for the 17-bit result store path.
// Lane geometry and FSM codes are collected here so every file agrees on them.
package result_store_writer_pkg;

    localparam int LANE_W          = 17;
    localparam int DEF_MAC_NUM     = 112;
    localparam int CNT_W           = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // Requested lane count clamped to the number of lanes physically present.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] req,
                                                   input int mac_num);
        logic [CNT_W-1:0] res;
        if (int'(req) > mac_num) begin
            res = CNT_W'(mac_num);
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/result_store_writer_lane_select.sv
// Combinational lane mux with optional ReLU clamp on the selected 17-bit lane.
// Out-of-range indices yield zero so the look-ahead select past the last lane is harmless.
module lane_select
    import result_store_writer_pkg::*;
#(
    parameter int MAC_NUM = DEF_MAC_NUM
) (
    input  logic [MAC_NUM*LANE_W-1:0] data_i,
    input  logic [CNT_W-1:0]          idx_i,
    input  logic                      relu_en_i,
    output logic [LANE_W-1:0]         lane_o
);

    logic [LANE_W-1:0] raw_s;

    // Select the indexed lane, then clamp negatives when ReLU is enabled.
    always_comb begin
        raw_s  = '0;
        lane_o = '0;
        if (int'(idx_i) < MAC_NUM) begin
            raw_s = data_i[int'(idx_i)*LANE_W +: LANE_W];
        end else begin
            raw_s = '0;
        end
        if (relu_en_i && raw_s[LANE_W-1]) begin
            lane_o = '0;
        end else begin
            lane_o = raw_s;
        end
    end

endmodule

// File: rtl/result_store_writer.sv
// Captures one MAC_NUM-lane result vector and streams its lanes into the feature-map
// BRAM at consecutive addresses, honouring back-pressure from the write port.
module result_store_writer
    import result_store_writer_pkg::*;
#(
    parameter int MAC_NUM = DEF_MAC_NUM,
    parameter int ADDR_W  = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MAC_NUM*LANE_W-1:0] store_data_17,
    input  logic [CNT_W-1:0]          lane_cnt,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      relu_en,
    input  logic                      wr_ready,
    output logic                      bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [LANE_W-1:0]         bram_din,
    output logic                      busy,
    output logic                      done
);

    wr_state_e                 state_q;
    logic [MAC_NUM*LANE_W-1:0] data_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          idx_q;
    logic [CNT_W-1:0]          idx_d;
    logic [ADDR_W-1:0]         addr_q;
    logic [ADDR_W-1:0]         addr_d;
    logic                      relu_q;
    logic                      we_q;
    logic                      busy_q;
    logic                      done_q;
    logic [LANE_W-1:0]         din_q;

    logic [MAC_NUM*LANE_W-1:0] sel_data_s;
    logic [CNT_W-1:0]          sel_idx_s;
    logic                      sel_relu_s;
    logic [LANE_W-1:0]         lane_s;
    logic [CNT_W-1:0]          eff_cnt_s;
    logic                      accept_s;

    assign eff_cnt_s = eff_count(lane_cnt, MAC_NUM);
    assign idx_d     = idx_q + 7'd1;
    assign addr_d    = addr_q + ADDR_W'(1'b1);
    assign accept_s  = (state_q == ST_IDLE) && start;

    // In IDLE the mux looks at the live inputs so lane 0 can be registered on the
    // capture edge; afterwards it looks one lane ahead of the one on the bus.
    always_comb begin
        sel_data_s = data_q;
        sel_idx_s  = idx_d;
        sel_relu_s = relu_q;
        if (state_q == ST_IDLE) begin
            sel_data_s = store_data_17;
            sel_idx_s  = 7'd0;
            sel_relu_s = relu_en;
        end else begin
            sel_data_s = data_q;
            sel_idx_s  = idx_d;
            sel_relu_s = relu_q;
        end
    end

    lane_select #(
        .MAC_NUM (MAC_NUM)
    ) u_lane_select (
        .data_i    (sel_data_s),
        .idx_i     (sel_idx_s),
        .relu_en_i (sel_relu_s),
        .lane_o    (lane_s)
    );

    // Result vector capture; deliberately left without reset.
    always_ff @(posedge clk) begin
        if (accept_s && !rst) begin
            data_q <= store_data_17;
        end
    end

    // Transfer FSM with registered BRAM strobe, address, data and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 7'd0;
            idx_q   <= 7'd0;
            addr_q  <= '0;
            relu_q  <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            din_q   <= 17'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        relu_q <= relu_en;
                        cnt_q  <= eff_cnt_s;
                        idx_q  <= 7'd0;
                        addr_q <= base_addr;
                        if (eff_cnt_s != 7'd0) begin
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            din_q   <= lane_s;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (idx_q == cnt_q - 7'd1) begin
                            state_q <= ST_DONE;
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_d;
                            addr_q <= addr_d;
                            din_q  <= lane_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/result_store_writer.md
# result_store_writer

Drain side of the output buffer's 17-bit store path. On a `start` pulse it captures one `store_data_17` vector (`MAC_NUM` lanes × 17 bits), applies optional ReLU per lane, and writes the lanes one per cycle into the feature-map BRAM. Writes go to consecutive addresses from `base_addr`, and the BRAM port can stall the writer. It sits between `output_buffer` and the next layer's feature-map memory. The controller FSM drives it once per output tile.

## Interface
- `MAC_NUM`, default 112: number of 17-bit lanes in the input vector (matches `def_header.vh`).
- `ADDR_W`, default 13: BRAM word-address width.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: single-cycle request; captures inputs when the block is idle.
- `store_data_17` input, `MAC_NUM*17`: lane j occupies bits `[j*17 +: 17]`; two's-complement Q4.13.
- `lane_cnt` input, 7: number of lanes to write, counted from lane 0; sampled on an accepted `start`.
- `base_addr` input, `ADDR_W`: address for lane 0; sampled on an accepted `start`.
- `relu_en` input, 1: when 1, negative lanes are written as 0; sampled on an accepted `start`.
- `wr_ready` input, 1: BRAM port accepts a write this cycle.
- `bram_we` output, 1: write strobe.
- `bram_addr` output, `ADDR_W`: write address.
- `bram_din` output, 17: write data.
- `busy` output, 1: high from the cycle after an accepted `start` until `done`.
- `done` output, 1: one-cycle pulse after the last write is accepted.

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - `start`=1 latches `store_data_17`, `base_addr` and `relu_en` into internal registers.
  - The effective count is min(`lane_cnt`, `MAC_NUM`) and is latched with them.
  - The lane index is cleared to 0.
  - Next state is WRITE if the count is greater than 0, otherwise DONE.
- WRITE:
  - `bram_we`=1.
  - `bram_addr` = `base_addr` + lane index, computed modulo 2^`ADDR_W` (wraps silently).
  - `bram_din` = lane[index]. If `relu_en`=1 and bit 16 of the lane is 1, `bram_din` = 0.
  - A write is accepted when `bram_we` and `wr_ready` are both 1; the index then increments.
  - After the accepted write of index count−1, next state is DONE.
  - While `wr_ready`=0, `bram_addr` and `bram_din` hold and `bram_we` stays 1.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored; the latched data is not disturbed.
- `store_data_17` may change after the capture cycle without affecting the transfer.
- `rst` in any state:
  - Next state is IDLE.
  - `bram_we`, `busy` and `done` go to 0.
  - The in-flight transfer is abandoned; no partial-completion pulse is issued.
- Reset values: `bram_we`=0, `bram_addr`=0, `bram_din`=0, `busy`=0, `done`=0.
- The internal data register is not reset.

## Timing
- All outputs are registered.
- Cycle 0: `start` is sampled.
- Cycle 1: first `bram_we`=1 with lane 0, and `busy`=1.
- With `wr_ready` held at 1, lane k is written in cycle 1+k.
- With `wr_ready` held at 1, `done` is high in cycle N+1 for N lanes; `busy` is 0 in that cycle.
- Total latency, `start` to `done`, is N+1 cycles plus the number of stall cycles.
- With N=0, `done` is high in cycle 1, `bram_we` is never asserted, and `busy` never rises.
- The earliest next accepted `start` is the cycle after `done`.
- `done` and a new `start` in the same cycle: the `start` is ignored.

## Structure
- `MAC_NUM`, the lane width (17) and the FSM state encodings go in the shared `def_header.vh` as `` `define `` constants, alongside `SCONV_1` and the other state codes.
- One sub-module, `lane_select`: a combinational `MAC_NUM`:1 mux of 17-bit lanes with the ReLU clamp, driven from the index register.
- Its output is registered into `bram_din` in the top level.
- Everything else (FSM, counter, address adder) lives in `result_store_writer`.

## Test plan
- **Basic transfer.** `lane_cnt`=4, `base_addr`=0x100, lanes = 0x00001, 0x1FFFF, 0x0ABCD, 0x10000, `relu_en`=0, `wr_ready`=1 → writes to 0x100..0x103 with those exact values in cycles 1–4, `done` in cycle 5.
- **ReLU.** Same data with `relu_en`=1 → data 0x00001, 0x00000, 0x0ABCD, 0x00000.
- **Stall.** `wr_ready` low for cycles 2–3 during a 3-lane write → lane 1 held on the bus for 3 cycles with address unchanged, `done` in cycle 6, no duplicate or skipped address.
- **Wrap and clamp.**
  - `base_addr`=0x1FFE, `lane_cnt`=3 → addresses 0x1FFE, 0x1FFF, 0x0000.
  - `lane_cnt`=127 → exactly 112 writes, `done` in cycle 113.
- **Degenerate start.**
  - `lane_cnt`=0 → `done` in cycle 1, zero writes.
  - `start` pulsed mid-transfer with new data → ignored, original data completes.
- **Reset mid-operation.** `rst` at cycle 3 of an 8-lane transfer → `bram_we`=0 and `busy`=0 from cycle 4, no `done`; a following `start` runs a clean transfer from lane 0.
